// File: rtl/rst_seq_pkg.sv
// Purpose: shared state encoding, link filter length and release decode helpers for rst_seq.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package rst_seq_pkg;

  typedef logic [3:0] state_t;

  localparam state_t IDLE      = 4'd0;
  localparam state_t ADC_WAIT  = 4'd1;
  localparam state_t DDC_GAP   = 4'd2;
  localparam state_t SRIO_GAP  = 4'd3;
  localparam state_t SRIO_WAIT = 4'd4;
  localparam state_t RUN       = 4'd5;
  localparam state_t RETRY     = 4'd6;
  localparam state_t HOLD      = 4'd7;
  localparam state_t FAULT     = 4'd8;

  // Consecutive link-down cycles in RUN before the SRIO stage is recycled.
  localparam int LINK_FILT   = 1024;
  localparam int LINK_FILT_W = $clog2(LINK_FILT);

  // Stage enables decoded from a state. Each stage is only released in states
  // where every earlier stage is also released, which is what keeps the
  // ADC -> DDC -> SRIO ordering invariant true by construction.
  function automatic logic adc_on(input state_t s);
    return s inside {ADC_WAIT, DDC_GAP, SRIO_GAP, SRIO_WAIT, RUN};
  endfunction

  function automatic logic ddc_on(input state_t s);
    return s inside {SRIO_GAP, SRIO_WAIT, RUN};
  endfunction

  function automatic logic srio_on(input state_t s);
    return s inside {SRIO_WAIT, RUN};
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Purpose: two-flop synchroniser for a single level signal, reset to 0.
// Latency: 2 clk_100M cycles from pin to q.
// Backpressure: none; level signal, no handshake.
module sync_2ff (
  input  logic clk_100M,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture; the first flop may go metastable and is never used directly.
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rst_seq.sv
// Purpose: ordered ADC -> DDC -> SRIO reset release with timeouts, retries and status; RST_SEQ_RELINK_EN adds SRIO re-release after link loss.
// Latency: all outputs registered; ready inputs pass a 2-flop synchroniser before the FSM sees them.
// Backpressure: none; adc_cal_done/srio_link_up are level ready handshakes, soft_rst is a one-cycle pulse.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int unsigned STAGE_GAP = 1000,
  parameter int unsigned ADC_TMO   = 10_000_000,
  parameter int unsigned SRIO_TMO  = 100_000_000,
  parameter int unsigned HOLD_CYC  = 1000,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned CNT_W     = 27
) (
  input  logic       clk_100M,
  input  logic       rst_n,
  input  logic       soft_rst,
  input  logic       adc_cal_done,
  input  logic       srio_link_up,
  output logic       rst_adc_n,
  output logic       rst_ddc_n,
  output logic       rst_srio_n,
  output logic       seq_done,
  output logic       fault,
  output logic [1:0] retry_cnt,
  output logic       link_lost
);

  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] ADC_LAST  = CNT_W'(ADC_TMO - 1);
  localparam logic [CNT_W-1:0] SRIO_LAST = CNT_W'(SRIO_TMO - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRY);

  logic             adc_cal_done_s;
  logic             srio_link_up_s;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] tmr;
  logic [1:0]       retry_nxt;
  logic             lost_set;

  sync_2ff u_sync_adc (
    .clk_100M (clk_100M),
    .rst_n    (rst_n),
    .d        (adc_cal_done),
    .q        (adc_cal_done_s)
  );

  sync_2ff u_sync_srio (
    .clk_100M (clk_100M),
    .rst_n    (rst_n),
    .d        (srio_link_up),
    .q        (srio_link_up_s)
  );

`ifdef RST_SEQ_RELINK_EN
  localparam logic [LINK_FILT_W-1:0] FILT_LAST = LINK_FILT_W'(LINK_FILT - 1);

  logic [LINK_FILT_W-1:0] filt_cnt;

  // Count consecutive link-down cycles in RUN; any up cycle or leaving RUN restarts the count.
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      filt_cnt <= '0;
    end else if (state == RUN && !srio_link_up_s && filt_cnt != FILT_LAST) begin
      filt_cnt <= filt_cnt + 1'b1;
    end else begin
      filt_cnt <= '0;
    end
  end
`endif

  // Next-state and retry bookkeeping; ready beats timeout, soft_rst beats everything.
  always_comb begin
    state_nxt = state;
    retry_nxt = retry_cnt;
    lost_set  = 1'b0;
    case (state)
      IDLE: begin
        if (tmr == GAP_LAST) state_nxt = ADC_WAIT;
      end
      ADC_WAIT: begin
        if (adc_cal_done_s)        state_nxt = DDC_GAP;
        else if (tmr == ADC_LAST)  state_nxt = RETRY;
      end
      DDC_GAP: begin
        if (tmr == GAP_LAST) state_nxt = SRIO_GAP;
      end
      SRIO_GAP: begin
        if (tmr == GAP_LAST) state_nxt = SRIO_WAIT;
      end
      SRIO_WAIT: begin
        if (srio_link_up_s)        state_nxt = RUN;
        else if (tmr == SRIO_LAST) state_nxt = RETRY;
      end
      RETRY: begin
        if (retry_cnt == RETRY_MAX) begin
          state_nxt = FAULT;
        end else begin
          retry_nxt = retry_cnt + 2'd1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (tmr == HOLD_LAST) state_nxt = ADC_WAIT;
      end
      RUN: begin
`ifdef RST_SEQ_RELINK_EN
        // Only a sustained outage counts; SRIO alone is recycled, retries untouched.
        if (!srio_link_up_s && filt_cnt == FILT_LAST) begin
          lost_set  = 1'b1;
          state_nxt = SRIO_GAP;
        end
`else
        if (!srio_link_up_s) lost_set = 1'b1;
`endif
      end
      FAULT: begin
        state_nxt = FAULT;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    if (soft_rst) begin
      state_nxt = HOLD;
      retry_nxt = 2'd0;
    end
  end

  // State and shared timer; the timer restarts on every transition and on soft_rst
  // (soft_rst in HOLD must still restart the full hold window).
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tmr   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || soft_rst) tmr <= '0;
      else                                tmr <= tmr + CNT_W'(1);
    end
  end

  // Outputs decoded from the next state so each change lands on the transition edge.
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      rst_adc_n  <= 1'b0;
      rst_ddc_n  <= 1'b0;
      rst_srio_n <= 1'b0;
      seq_done   <= 1'b0;
      fault      <= 1'b0;
      retry_cnt  <= 2'd0;
      link_lost  <= 1'b0;
    end else begin
      rst_adc_n  <= adc_on(state_nxt);
      rst_ddc_n  <= ddc_on(state_nxt);
      rst_srio_n <= srio_on(state_nxt);
      seq_done   <= (state_nxt == RUN);
      fault      <= (state_nxt == FAULT);
      retry_cnt  <= retry_nxt;
      link_lost  <= link_lost | lost_set;
    end
  end

endmodule
